// File: rtl/me_row_ctrl.sv
// Motion-estimation row controller: streams a current block and its reference window into a
// PE row, waits for the row's best match (with a timeout) and hands back the motion vector.
`timescale 1ns/1ps
module me_row_ctrl #(
    parameter int unsigned BLK_SIZE = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] cur_base,
    input  logic [ADDR_W-1:0] ref_base,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [7:0]        cur_data,
    input  logic [7:0]        ref_data,
    output logic              row_clr,
    output logic              row_start,
    output logic [7:0]        row_c,
    output logic [7:0]        row_p,
    input  logic              row_done,
    input  logic [7:0]        row_mi,
    input  logic [7:0]        row_mj,
    output logic              mv_valid,
    input  logic              mv_ready,
    output logic [7:0]        mv_i,
    output logic [7:0]        mv_j,
    output logic              mv_err
);

    localparam int unsigned BS_SQ   = BLK_SIZE * BLK_SIZE;
    localparam int unsigned BS_CUBE = BS_SQ * BLK_SIZE;
    localparam int unsigned KW      = $clog2(BS_CUBE);
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StWait, StOut} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_base_q, cur_base_d, ref_base_q, ref_base_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, ref_addr_q, ref_addr_d;
    logic [KW-1:0]     k_q, k_d, k_nxt;
    logic [TW-1:0]     to_q, to_d;
    logic [7:0]        mv_i_q, mv_i_d, mv_j_q, mv_j_d;
    logic              mv_err_q, mv_err_d;
    logic [7:0]        row_c_q, row_c_d, row_p_q, row_p_d;

    function automatic logic [ADDR_W-1:0] cur_off(input logic [KW-1:0] k);
        return ADDR_W'(k % KW'(BS_SQ));
    endfunction

    function automatic logic [ADDR_W-1:0] ref_off(input logic [KW-1:0] k);
        return ADDR_W'((k / KW'(BS_SQ)) * KW'(BLK_SIZE)) + cur_off(k);
    endfunction

    // Address registers present the address for index k during FEED cycle k.
    always_comb begin
        state_d    = state_q;
        cur_base_d = cur_base_q;
        ref_base_d = ref_base_q;
        cur_addr_d = cur_addr_q;
        ref_addr_d = ref_addr_q;
        k_d        = k_q;
        k_nxt      = k_q + KW'(1);
        to_d       = to_q;
        mv_i_d     = mv_i_q;
        mv_j_d     = mv_j_q;
        mv_err_d   = mv_err_q;
        row_c_d    = cur_data;
        row_p_d    = ref_data;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cur_base_d = cur_base;
                    ref_base_d = ref_base;
                    state_d    = StClear;
                end
            end
            StClear: begin
                k_d        = '0;
                to_d       = '0;
                cur_addr_d = cur_base_q;
                ref_addr_d = ref_base_q;
                state_d    = StFeed;
            end
            StFeed: begin
                if (k_q == KW'(BS_CUBE - 1)) begin
                    to_d    = '0;
                    state_d = StWait;
                end else begin
                    k_d        = k_nxt;
                    cur_addr_d = cur_base_q + cur_off(k_nxt);
                    ref_addr_d = ref_base_q + ref_off(k_nxt);
                end
            end
            StWait: begin
                // A done in the expiry cycle still reports the real result.
                if (row_done) begin
                    mv_i_d   = row_mi;
                    mv_j_d   = row_mj;
                    mv_err_d = 1'b0;
                    state_d  = StOut;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    mv_i_d   = 8'hFF;
                    mv_j_d   = 8'hFF;
                    mv_err_d = 1'b1;
                    state_d  = StOut;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            StOut: begin
                if (mv_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cur_base_q <= '0;
            ref_base_q <= '0;
            cur_addr_q <= '0;
            ref_addr_q <= '0;
            k_q        <= '0;
            to_q       <= '0;
            mv_i_q     <= '0;
            mv_j_q     <= '0;
            mv_err_q   <= 1'b0;
            row_c_q    <= '0;
            row_p_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_base_q <= cur_base_d;
            ref_base_q <= ref_base_d;
            cur_addr_q <= cur_addr_d;
            ref_addr_q <= ref_addr_d;
            k_q        <= k_d;
            to_q       <= to_d;
            mv_i_q     <= mv_i_d;
            mv_j_q     <= mv_j_d;
            mv_err_q   <= mv_err_d;
            row_c_q    <= row_c_d;
            row_p_q    <= row_p_d;
        end
    end

    // Memory data lags the address by one cycle and row_c/row_p add another, so the first
    // valid pair lines up with FEED index 2.
    assign row_start = (state_q == StFeed) && (k_q == KW'(2));
    assign row_clr   = reset || (state_q == StClear);
    assign req_ready = (state_q == StIdle);
    assign mv_valid  = (state_q == StOut);
    assign cur_addr  = cur_addr_q;
    assign ref_addr  = ref_addr_q;
    assign row_c     = row_c_q;
    assign row_p     = row_p_q;
    assign mv_i      = mv_i_q;
    assign mv_j      = mv_j_q;
    assign mv_err    = mv_err_q;

endmodule
